// File: rtl/uart_rx_fifo_if.sv
// Character handshake bundle between UART receiver, RX FIFO and register read side.
// The slave modport is the FIFO's view of the bundle.
interface uart_rx_fifo_if #(parameter int DW = 8);
  // Receiver -> FIFO push side.
  logic [DW-1:0] data_i;
  logic          perr_i;
  logic          valid_i;
  logic          ready_o;

  // FIFO -> read side, head of queue shown ahead of the pop.
  logic [DW-1:0] data_o;
  logic          perr_o;
  logic          valid_o;
  logic          ready_i;

  modport slave  (input  data_i, perr_i, valid_i, ready_i,
                  output ready_o, data_o, perr_o, valid_o);
  modport master (output data_i, perr_i, valid_i, ready_i,
                  input  ready_o, data_o, perr_o, valid_o);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: show-ahead circular buffer of {perr, data} entries with
// trigger-level / character-timeout interrupt conditions and a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clr_i,
  uart_rx_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic [1:0]               cfg_trig_i,
  input  logic [15:0]              cfg_timeout_i,
  output logic                     irq_trig_o,
  output logic                     irq_timeout_o,
  output logic                     overflow_o,
  input  logic                     ovf_clr_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][DW:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_nxt, trig_lvl;
  logic [15:0]            tmo_cnt, tmo_nxt;
  logic                   push, pop, tmo_set;

  assign bus.ready_o = (count != CW'(DEPTH));
  assign bus.valid_o = (count != '0);
  assign {bus.perr_o, bus.data_o} = mem[rd_ptr];
  assign count_o = count;

  // A flush swallows any push/pop presented in the same cycle.
  assign push = bus.valid_i && bus.ready_o && !clr_i;
  assign pop  = bus.ready_i && bus.valid_o && !clr_i;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  always_comb begin
    trig_lvl = CW'(1);
    case (cfg_trig_i)
      2'b01:   trig_lvl = CW'(DEPTH / 4);
      2'b10:   trig_lvl = CW'(DEPTH / 2);
      2'b11:   trig_lvl = CW'(DEPTH - 2);
      default: trig_lvl = CW'(1);
    endcase
  end
  assign irq_trig_o = (count >= trig_lvl);

  // Idle timer: runs only while data sits untouched, saturating at the limit.
  always_comb begin
    tmo_nxt = tmo_cnt;
    if (clr_i || push || pop || count == '0 || cfg_timeout_i == '0) tmo_nxt = '0;
    else if (tmo_cnt < cfg_timeout_i)                               tmo_nxt = tmo_cnt + 16'd1;
    else                                                            tmo_nxt = cfg_timeout_i;
  end
  assign tmo_set = (cfg_timeout_i != '0) && (tmo_nxt == cfg_timeout_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {bus.perr_i, bus.data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt       <= '0;
      irq_timeout_o <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      if (clr_i || pop || count_nxt == '0) irq_timeout_o <= 1'b0;
      else if (tmo_set)                    irq_timeout_o <= 1'b1;
    end
  end

  // A dropped character beats a same-cycle software clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                          overflow_o <= 1'b0;
    else if (clr_i)                       overflow_o <= 1'b0;
    else if (bus.valid_i && !bus.ready_o) overflow_o <= 1'b1;
    else if (ovf_clr_i)                   overflow_o <= 1'b0;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        clr_i = 1'b0;
  logic        ovf_clr_i = 1'b0;
  logic [1:0]  cfg_trig_i = 2'b00;
  logic [15:0] cfg_timeout_i = 16'd0;
  logic [4:0]  count_o;
  logic        irq_trig_o, irq_timeout_o, overflow_o;

  uart_rx_fifo_if #(.DW(DW)) bus();

  uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i), .bus(bus),
    .count_o(count_o), .cfg_trig_i(cfg_trig_i), .cfg_timeout_i(cfg_timeout_i),
    .irq_trig_o(irq_trig_o), .irq_timeout_o(irq_timeout_o),
    .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Reference model: FIFO contents, flags and idle-cycle count.
  logic [DW:0] mq[$];
  logic [DW:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_tmo = 1'b0;
  int          quiet = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int trig_lvl(input logic [1:0] t);
    case (t)
      2'd0: return 1;
      2'd1: return DEPTH / 4;
      2'd2: return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  // One clock: present inputs, let the edge happen, advance the model.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic p,
                     input logic r, input logic c, input logic oc);
    int  sz0;
    logic apush, apop;
    bus.valid_i = v; bus.data_i = d; bus.perr_i = p;
    bus.ready_i = r; clr_i = c; ovf_clr_i = oc;
    @(posedge clk_i);
    sz0   = mq.size();
    apush = v && !c && sz0 < DEPTH;
    apop  = r && !c && sz0 > 0;
    if (c) begin
      mq.delete(); sb.delete();
      m_ovf = 1'b0; m_tmo = 1'b0; quiet = 0;
    end else begin
      if (v && sz0 == DEPTH) m_ovf = 1'b1;
      else if (oc)           m_ovf = 1'b0;
      if (apop)  void'(mq.pop_front());
      if (apush) begin mq.push_back({p, d}); sb.push_back({p, d}); end
      if (apush || apop || sz0 == 0 || cfg_timeout_i == 0) quiet = 0;
      else if (quiet < 70000) quiet++;
      if (apop) m_tmo = 1'b0;
      if (mq.size() == 0) m_tmo = 1'b0;
      else if (cfg_timeout_i != 0 && quiet >= int'(cfg_timeout_i)) m_tmo = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && mq.size() > 0; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: status against model every cycle; popped entries against scoreboard.
  always @(negedge clk_i) begin
    if (chk_en && rstn_i) begin
      chk("count", 32'(count_o), 32'(mq.size()));
      chk("valid", 32'(bus.valid_o), 32'(mq.size() != 0));
      chk("ready", 32'(bus.ready_o), 32'(mq.size() != DEPTH));
      chk("irq_trig", 32'(irq_trig_o), 32'(mq.size() >= trig_lvl(cfg_trig_i)));
      chk("irq_timeout", 32'(irq_timeout_o), 32'(m_tmo));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      if (bus.valid_o && bus.ready_i && !clr_i) begin
        if (sb.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
        else chk("pop_entry", 32'({bus.perr_o, bus.data_o}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i = 1'b0; bus.data_i = '0; bus.perr_i = 1'b0; bus.ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(bus.ready_o), 32'(1));
    chk("rst_valid", 32'(bus.valid_o), 32'(0));
    chk("rst_data", 32'(bus.data_o), 32'(0));
    chk("rst_perr", 32'(bus.perr_o), 32'(0));
    chk("rst_count", 32'(count_o), 32'(0));
    chk("rst_irqs", 32'({irq_trig_o, irq_timeout_o, overflow_o}), 32'(0));
    rstn_i = 1'b1;
    chk_en = 1'b1;

    // Single character round trip.
    cyc(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.valid_o), 32'(1));
    chk("t1_data", 32'(bus.data_o), 32'h41);
    chk("t1_count", 32'(count_o), 32'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_empty", 32'({bus.valid_o, count_o}), 32'(0));

    // Fill, overflow, drain in order, clear overflow.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_full_ready", 32'(bus.ready_o), 32'(0));
    chk("t2_full_count", 32'(count_o), 32'(16));
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_overflow", 32'(overflow_o), 32'(1));
    drain();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_ovf_clr", 32'(overflow_o), 32'(0));

    // Trigger level DEPTH/2.
    cfg_trig_i = 2'b10;
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_trig7", 32'(irq_trig_o), 32'(0));
    cyc(1'b1, 8'h27, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_trig8", 32'(irq_trig_o), 32'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_trig_pop", 32'(irq_trig_o), 32'(0));
    drain();
    cfg_trig_i = 2'b00;

    // Character timeout of 100 cycles, then disabled.
    cfg_timeout_i = 16'd100;
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(99);
    chk("t4_tmo_early", 32'(irq_timeout_o), 32'(0));
    idle(1);
    chk("t4_tmo_exact", 32'(irq_timeout_o), 32'(1));
    idle(20);
    chk("t4_tmo_sticky", 32'(irq_timeout_o), 32'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_tmo_pop", 32'({irq_timeout_o, bus.valid_o}), 32'(0));
    cfg_timeout_i = 16'd0;
    cyc(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(150);
    chk("t4_tmo_off", 32'(irq_timeout_o), 32'(0));
    drain();

    // Parity flag travels with its character.
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_head", 32'({bus.perr_o, bus.data_o}), 32'h155);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_next", 32'({bus.perr_o, bus.data_o}), 32'h066);
    drain();

    // Simultaneous push/pop, then flush with a concurrent push.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h75, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_pushpop", 32'(count_o), 32'(5));
    cyc(1'b1, 8'h76, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_clr", 32'({count_o, bus.valid_o, overflow_o}), 32'(0));

    // Randomized traffic with alternating fill/drain bias.
    cfg_timeout_i = 16'($urandom_range(3, 12));
    for (int i = 0; i < 1600; i++) begin
      automatic bit fill = ((i / 100) % 2) == 0;
      automatic logic v  = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      automatic logic r  = fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (i % 200 == 0) cfg_trig_i = 2'($urandom);
      cyc(v, 8'($urandom), 1'($urandom), r, ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 19) == 0));
      if (i == 777) begin
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        chk("async_rst", 32'({count_o, bus.valid_o, overflow_o, irq_timeout_o}), 32'(0));
        mq.delete(); sb.delete();
        m_ovf = 1'b0; m_tmo = 1'b0; quiet = 0;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        chk_en = 1'b1;
      end
    end
    drain();
    idle(2);
    chk("sb_empty", 32'(sb.size()), 32'(0));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It accepts completed characters and their per-character parity error flag from the receiver's valid/ready interface, and stores them in a circular FIFO. It presents them show-ahead to the APB register/read side, and generates trigger-level and character-timeout interrupt conditions plus a sticky overflow flag.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
DW, 8, character data width

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset, asynchronous, active-low
clr_i  input  1  synchronous flush of contents and status
data_i  input  DW  character from receiver
perr_i  input  1  parity error for the character on data_i; sampled with data_i
valid_i  input  1  single-cycle push request from receiver
ready_o  output  1  FIFO can accept a character (not full)
data_o  output  DW  head-of-FIFO character (show-ahead)
perr_o  output  1  parity flag of head entry
valid_o  output  1  FIFO not empty
ready_i  input  1  pop request from read side
count_o  output  $clog2(DEPTH)+1  current occupancy
cfg_trig_i  input  2  trigger level select: 00=1, 01=DEPTH/4, 10=DEPTH/2, 11=DEPTH-2
cfg_timeout_i  input  16  character timeout in clk cycles; 0 disables
irq_trig_o  output  1  count_o >= selected trigger level
irq_timeout_o  output  1  sticky character-timeout indication
overflow_o  output  1  sticky: a character was dropped
ovf_clr_i  input  1  clear overflow_o

Behaviour:
- Reset: wr_ptr=rd_ptr=0, count=0, storage array cleared to 0, timeout counter=0. Outputs after reset: ready_o=1, valid_o=0, data_o=0, perr_o=0, count_o=0, irq_trig_o=0, irq_timeout_o=0, overflow_o=0.
- Storage: DEPTH entries of {perr, data}. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is a separate register.
- ready_o = (count != DEPTH). It is derived combinationally from the count register only, with no path from ready_i.
- Push: valid_i && ready_o. Writes {perr_i, data_i} at wr_ptr and increments wr_ptr. The entry is visible on data_o/valid_o the next cycle (1-cycle latency when empty).
- Overflow: valid_i && !ready_o. The character is dropped, storage and pointers are unchanged, and overflow_o <= 1. This applies even if a pop occurs in the same cycle.
- Pop: ready_i && valid_o. Increments rd_ptr. ready_i while empty is ignored, with no underflow and no pointer change.
- Simultaneous push and pop (neither full nor empty): both pointers advance and count is unchanged. With count=1, the new entry becomes the head next cycle.
- data_o/perr_o = storage[rd_ptr], combinational read of the registered array. valid_o = (count != 0).
- irq_trig_o: combinational compare of the count register against the selected level. There is no hysteresis.
- Timeout counter (16 bit):
  - Cleared on any push, any pop, when count==0, or on clr_i.
  - Otherwise it increments while count!=0 and saturates at cfg_timeout_i.
  - When it reaches cfg_timeout_i != 0, irq_timeout_o <= 1.
  - irq_timeout_o is cleared by the next pop, by clr_i, or when count becomes 0. A new push alone does not clear it.
  - With cfg_timeout_i=0, the counter is held at 0 and irq_timeout_o is never set.
- overflow_o clear: cleared by ovf_clr_i or clr_i. If an overflow event and ovf_clr_i occur in the same cycle, set wins.
- clr_i: next cycle wr_ptr=rd_ptr=count=0, timeout state and overflow_o are cleared, and storage contents are left unchanged. A push or pop in the same cycle as clr_i is discarded. clr_i does not itself set overflow_o.
- Mid-operation reset: everything returns to reset values immediately (asynchronous). Stored data is lost.

Test Plan:
- Reset, then push 0x41 with perr_i=0. Next cycle: valid_o=1, data_o=0x41, count_o=1. Pop with ready_i=1. Next cycle: valid_o=0, count_o=0.
- Push 16 chars 0x00..0x0F (DEPTH=16). Required: ready_o=0 at count 16. Push 0xAA → dropped and overflow_o=1. Popping all yields 0x00..0x0F in order with no 0xAA. ovf_clr_i pulse → overflow_o=0.
- cfg_trig_i=10. Push 7 chars → irq_trig_o=0. 8th push → irq_trig_o=1 the next cycle. One pop → irq_trig_o=0.
- cfg_timeout_i=100. Push 1 char, then idle. Required: irq_timeout_o=1 exactly 100 cycles after the push and stays set. Pop → irq_timeout_o=0, valid_o=0. Repeat with cfg_timeout_i=0 → irq_timeout_o never asserts.
- Push 0x55 with perr_i=1, then 0x66 with perr_i=0. Head shows data_o=0x55, perr_o=1. After pop: data_o=0x66, perr_o=0.
- Fill 5 entries, push and pop on the same cycle → count_o stays 5. Assert clr_i concurrently with push → next cycle count_o=0, valid_o=0, overflow_o=0.
